memory_access_controller: RTL and testbench
===========================================

Name: memory_access_controller

Overview:
- Sequences the memory-stage data-bus access for the pipelined MIPS core. Handshakes loads/stores from the memory stage onto an Avalon-style master port with waitrequest, and stalls the pipeline while the bus is busy.
- Returns load data to the memory/writeback pipeline boundary and tracks the HALT instruction so the CPU reports inactive only after all outstanding accesses have drained.

Parameters:
- WAIT_CNT_W, 8, width of the wait-cycle counter; the watchdog limit is 2^WAIT_CNT_W-1 cycles.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- mem_read_memory  in  1  memory-stage instruction is a load
- mem_write_memory  in  1  memory-stage instruction is a store
- HALT_memory  in  1  memory-stage instruction is HALT
- address_memory  in  32  byte address from the ALU
- write_data_memory  in  32  store data
- byteenable_memory  in  4  lane enables
- data_address  out  32  bus address
- data_read  out  1  bus read strobe
- data_write  out  1  bus write strobe
- data_writedata  out  32  bus write data
- data_byteenable  out  4  bus lane enables
- data_waitrequest  in  1  bus not ready
- data_readdata  in  32  bus read data, valid when data_read=1 and data_waitrequest=0
- read_data_memory  out  32  load result to the memory/writeback register
- stall_memory  out  1  freeze fetch through memory stages; bubble into writeback
- active  out  1  CPU running; low once HALT has retired
- bus_error  out  1  sticky; set on watchdog expiry or on simultaneous read and write

Behaviour:
- Reset (async):
  - state=IDLE; data_read=0, data_write=0; data_address, data_writedata, data_byteenable=0.
  - read_data_memory=0, stall_memory=0, active=1, bus_error=0, wait counter=0.
  - Reset mid-access drops the strobes immediately; the access is abandoned.
- States: IDLE, ACCESS, HALTED.
- IDLE:
  - If mem_write_memory or mem_read_memory is high, drive the strobes combinationally in the same cycle, with address, writedata and byteenable taken from the memory-stage inputs.
  - Write has priority. If both are high, issue a write only and set bus_error.
  - If data_waitrequest=0, the access completes this cycle: stall_memory=0, zero extra latency.
  - If data_waitrequest=1: stall_memory=1 combinationally; capture address, data, byteenable and op into holding registers; go to ACCESS; wait counter=1.
  - Else if HALT_memory: go to HALTED next cycle.
  - byteenable=0 with an op is still issued on the bus.
- ACCESS:
  - Strobes and bus fields are driven from the holding registers, not from the inputs.
  - stall_memory = data_waitrequest.
  - When data_waitrequest=0: complete; go to IDLE next cycle; wait counter cleared.
  - While waiting, the wait counter increments and saturates at its maximum value.
- Load completion (either state): read_data_memory = data_readdata combinationally in the completing cycle. The value is also registered and held until the next load completes. Stores do not alter it.
- HALT arriving while an access is in ACCESS is not seen: the pipeline is stalled, so HALT is taken from IDLE after completion.
- HALTED:
  - active=0; no strobes; stall_memory=0.
  - Sticky until reset; all requests are ignored.
- bus_error stays high once set; only reset clears it.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined: in ACCESS, when the wait counter reaches 2^WAIT_CNT_W-1 with data_waitrequest still 1:
  - deassert the strobes and set bus_error;
  - force completion: stall_memory=0 that cycle, read_data_memory=32'hDEADBEEF for a load;
  - return to IDLE.
- Undefined: no timeout; the controller waits indefinitely and bus_error reports only the read/write conflict.

Test Plan:
- Load, addr=0x1000, waitrequest=0, readdata=0x12345678 -> data_read=1 for one cycle, stall_memory=0, read_data_memory=0x12345678 in the same cycle.
- Store, addr=0x2004, data=0xCAFEF00D, byteenable=4'b0011, waitrequest high for 3 cycles -> stall_memory high for exactly 3 cycles; data_write held with identical address, data and byteenable for 4 cycles; IDLE next.
- Load with waitrequest high for 2 cycles while the inputs change -> bus fields stay at the captured values; read_data_memory updates only in the completing cycle, then holds.
- Read and write both high, waitrequest=0 -> only data_write=1; bus_error=1 and stays 1.
- HALT_memory in IDLE -> active=0 next cycle; a later load request produces no strobe; assert reset -> active=1 and bus_error=0 immediately.
- With MEM_TIMEOUT_EN and WAIT_CNT_W=3, waitrequest held high -> forced completion after 7 wait cycles; bus_error=1, read_data_memory=0xDEADBEEF, strobes low.

Source files
------------

// File: rtl/memory_access_controller.sv
// Memory-stage data-bus sequencer: Avalon-style master with waitrequest, pipeline stall and HALT drain.
// Optional bus watchdog enabled by defining MEM_TIMEOUT_EN.
module memory_access_controller #(
  parameter int WAIT_CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_memory,
  input  logic        mem_write_memory,
  input  logic        HALT_memory,
  input  logic [31:0] address_memory,
  input  logic [31:0] write_data_memory,
  input  logic [3:0]  byteenable_memory,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  output logic [3:0]  data_byteenable,
  input  logic        data_waitrequest,
  input  logic [31:0] data_readdata,
  output logic [31:0] read_data_memory,
  output logic        stall_memory,
  output logic        active,
  output logic        bus_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_HALTED
  } state_t;

  localparam logic [WAIT_CNT_W-1:0] WMAX = '1;
`ifdef MEM_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;
`endif

  state_t                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  wr_q, wr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [WAIT_CNT_W-1:0] wcnt_q, wcnt_d;

  // Requests are masked during reset so strobes drop immediately.
  logic req_w, req_r;
  assign req_w = mem_write_memory & ~reset;
  assign req_r = mem_read_memory & ~reset;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    be_d             = be_q;
    wr_d             = wr_q;
    rdata_d          = rdata_q;
    err_d            = err_q;
    wcnt_d           = wcnt_q;
    data_address     = '0;
    data_read        = 1'b0;
    data_write       = 1'b0;
    data_writedata   = '0;
    data_byteenable  = '0;
    stall_memory     = 1'b0;
    read_data_memory = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_w | req_r) begin
          data_write      = req_w;
          data_read       = ~req_w;
          data_address    = address_memory;
          data_writedata  = write_data_memory;
          data_byteenable = byteenable_memory;
          if (req_w & req_r) err_d = 1'b1;
          if (data_waitrequest) begin
            stall_memory = 1'b1;
            state_d      = S_ACCESS;
            addr_d       = address_memory;
            wdata_d      = write_data_memory;
            be_d         = byteenable_memory;
            wr_d         = req_w;
            wcnt_d       = WAIT_CNT_W'(1);
          end else if (!req_w) begin
            read_data_memory = data_readdata;
            rdata_d          = data_readdata;
          end
        end else if (HALT_memory && !reset) begin
          state_d = S_HALTED;
        end
      end
      S_ACCESS: begin
        data_write      = wr_q;
        data_read       = ~wr_q;
        data_address    = addr_q;
        data_writedata  = wdata_q;
        data_byteenable = be_q;
        stall_memory    = data_waitrequest;
        if (!data_waitrequest) begin
          state_d = S_IDLE;
          wcnt_d  = '0;
          if (!wr_q) begin
            read_data_memory = data_readdata;
            rdata_d          = data_readdata;
          end
        end else begin
`ifdef MEM_TIMEOUT_EN
          if (wcnt_q == WMAX) begin
            data_write   = 1'b0;
            data_read    = 1'b0;
            stall_memory = 1'b0;
            err_d        = 1'b1;
            state_d      = S_IDLE;
            wcnt_d       = '0;
            if (!wr_q) begin
              read_data_memory = TIMEOUT_DATA;
              rdata_d          = TIMEOUT_DATA;
            end
          end else
`endif
          begin
            if (wcnt_q != WMAX) wcnt_d = wcnt_q + WAIT_CNT_W'(1);
          end
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign active    = (state_q != S_HALTED);
  assign bus_error = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_memory_access_controller.sv
// Bench for memory_access_controller: vector table, load scoreboard, multi-cycle sequences.
// Timeout sequence is selected by MEM_TIMEOUT_EN.
module tb_memory_access_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_memory, mem_write_memory, HALT_memory;
  logic [31:0] address_memory, write_data_memory;
  logic [3:0]  byteenable_memory;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_read, data_write, data_waitrequest;
  logic [3:0]  data_byteenable;
  logic [31:0] read_data_memory;
  logic        stall_memory, active, bus_error;

  memory_access_controller #(.WAIT_CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .mem_read_memory(mem_read_memory),
    .mem_write_memory(mem_write_memory),
    .HALT_memory(HALT_memory),
    .address_memory(address_memory),
    .write_data_memory(write_data_memory),
    .byteenable_memory(byteenable_memory),
    .data_address(data_address),
    .data_read(data_read),
    .data_write(data_write),
    .data_writedata(data_writedata),
    .data_byteenable(data_byteenable),
    .data_waitrequest(data_waitrequest),
    .data_readdata(data_readdata),
    .read_data_memory(read_data_memory),
    .stall_memory(stall_memory),
    .active(active),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, wd;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        e_rd, e_wr;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic [31:0] e_rdm;
  } vec_t;

  vec_t        vecs[5];
  logic [31:0] sbq[$];
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic halt,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic wt, input logic [31:0] rdat);
    mem_read_memory   = rd;
    mem_write_memory  = wr;
    HALT_memory       = halt;
    address_memory    = addr;
    write_data_memory = wd;
    byteenable_memory = be;
    data_waitrequest  = wt;
    data_readdata     = rdat;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
  endtask

  // Settle mid-cycle; a completed load pops the scoreboard.
  task automatic settle();
    #3;
    if (data_read && !data_waitrequest) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got load completion want none");
      end else begin
        chk("sb_rdata", read_data_memory, sbq.pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int stl, wrc, rdc;
    vecs[0] = '{1,0,32'h1000,32'h0,4'hF,32'h12345678, 1,0,32'h1000,32'h0,4'hF,32'h12345678};
    vecs[1] = '{0,1,32'h2004,32'hCAFEF00D,4'h3,32'hFFFFFFFF, 0,1,32'h2004,32'hCAFEF00D,4'h3,32'h12345678};
    vecs[2] = '{0,0,32'h2008,32'h1,4'hF,32'h0000FFFF, 0,0,32'h0,32'h0,4'h0,32'h12345678};
    vecs[3] = '{1,0,32'h3000,32'h7,4'h0,32'hA5A5A5A5, 1,0,32'h3000,32'h7,4'h0,32'hA5A5A5A5};
    vecs[4] = '{0,0,32'h0,32'h0,4'h0,32'h5A5A5A5A, 0,0,32'h0,32'h0,4'h0,32'hA5A5A5A5};

    reset = 1'b1;
    idle();
    step();
    settle();
    chk("rst_read", data_read, 0);
    chk("rst_write", data_write, 0);
    chk("rst_addr", data_address, 0);
    chk("rst_stall", stall_memory, 0);
    chk("rst_active", active, 1);
    chk("rst_err", bus_error, 0);
    chk("rst_rdm", read_data_memory, 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].rd, vecs[i].wr, 0, vecs[i].addr, vecs[i].wd,
            vecs[i].be, 0, vecs[i].rdata);
      if (vecs[i].rd && !vecs[i].wr) sbq.push_back(vecs[i].rdata);
      settle();
      chk($sformatf("v%0d_rd", i), data_read, vecs[i].e_rd);
      chk($sformatf("v%0d_wr", i), data_write, vecs[i].e_wr);
      chk($sformatf("v%0d_addr", i), data_address, vecs[i].e_addr);
      chk($sformatf("v%0d_wd", i), data_writedata, vecs[i].e_wd);
      chk($sformatf("v%0d_be", i), data_byteenable, vecs[i].e_be);
      chk($sformatf("v%0d_stall", i), stall_memory, 0);
      chk($sformatf("v%0d_rdm", i), read_data_memory, vecs[i].e_rdm);
      step();
    end

    stl = 0;
    wrc = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) drive(0, 1, 0, 32'h2004, 32'hCAFEF00D, 4'b0011, 1, 32'h0);
      else drive(0, 1, 0, 32'hBAD0, 32'h0, 4'hF, (c < 3), 32'h0);
      settle();
      stl += int'(stall_memory);
      wrc += int'(data_write);
      chk($sformatf("sA%0d_addr", c), data_address, 32'h2004);
      chk($sformatf("sA%0d_wd", c), data_writedata, 32'hCAFEF00D);
      chk($sformatf("sA%0d_be", c), data_byteenable, 4'b0011);
      step();
    end
    idle();
    settle();
    chk("sA_idle_wr", data_write, 0);
    chk("sA_stall_cycles", stl, 3);
    chk("sA_write_cycles", wrc, 4);
    chk("sA_rdm_kept", read_data_memory, 32'hA5A5A5A5);
    step();

    drive(1, 0, 0, 32'h4000, 32'h0, 4'hF, 1, 32'h11111111);
    sbq.push_back(32'h87654321);
    settle();
    chk("sB0_stall", stall_memory, 1);
    chk("sB0_rdm", read_data_memory, 32'hA5A5A5A5);
    step();
    drive(1, 0, 0, 32'h5000, 32'h9, 4'h1, 1, 32'h22222222);
    settle();
    chk("sB1_addr", data_address, 32'h4000);
    chk("sB1_be", data_byteenable, 4'hF);
    chk("sB1_stall", stall_memory, 1);
    chk("sB1_rdm", read_data_memory, 32'hA5A5A5A5);
    step();
    drive(1, 0, 0, 32'h5000, 32'h9, 4'h1, 0, 32'h87654321);
    settle();
    chk("sB2_addr", data_address, 32'h4000);
    chk("sB2_stall", stall_memory, 0);
    chk("sB2_rdm", read_data_memory, 32'h87654321);
    step();
    idle();
    settle();
    chk("sB3_rd", data_read, 0);
    chk("sB3_rdm", read_data_memory, 32'h87654321);
    step();

`ifdef MEM_TIMEOUT_EN
    stl = 0;
    drive(1, 0, 0, 32'h6000, 32'h0, 4'hF, 1, 32'h33333333);
    for (int c = 0; c < 7; c++) begin
      settle();
      stl += int'(stall_memory);
      step();
    end
    settle();
    chk("to_rd", data_read, 0);
    chk("to_stall", stall_memory, 0);
    chk("to_rdm", read_data_memory, 32'hDEADBEEF);
    chk("to_stall_cycles", stl, 7);
    step();
    idle();
    settle();
    chk("to_err", bus_error, 1);
    chk("to_rdm_hold", read_data_memory, 32'hDEADBEEF);
    chk("to_idle_rd", data_read, 0);
    step();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();
`else
    stl = 0;
    rdc = 0;
    drive(1, 0, 0, 32'h6000, 32'h0, 4'hF, 1, 32'h33333333);
    sbq.push_back(32'h0BADF00D);
    for (int c = 0; c < 12; c++) begin
      settle();
      stl += int'(stall_memory);
      rdc += int'(data_read);
      step();
    end
    drive(1, 0, 0, 32'h6000, 32'h0, 4'hF, 0, 32'h0BADF00D);
    settle();
    chk("sat_stall_end", stall_memory, 0);
    chk("sat_rdm", read_data_memory, 32'h0BADF00D);
    step();
    idle();
    settle();
    chk("sat_err", bus_error, 0);
    chk("sat_stall_cycles", stl, 12);
    chk("sat_read_cycles", rdc, 12);
    step();
`endif

    drive(1, 1, 0, 32'h7000, 32'h55, 4'hF, 0, 32'h44444444);
    settle();
    chk("cf_rd", data_read, 0);
    chk("cf_wr", data_write, 1);
    chk("cf_stall", stall_memory, 0);
    step();
    idle();
    settle();
    chk("cf_err", bus_error, 1);
    step();
    settle();
    chk("cf_err_sticky", bus_error, 1);
    step();

    drive(0, 0, 1, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    settle();
    chk("h_active_pre", active, 1);
    step();
    drive(1, 0, 0, 32'h8000, 32'h0, 4'hF, 0, 32'h66666666);
    settle();
    chk("h_active", active, 0);
    chk("h_rd", data_read, 0);
    chk("h_stall", stall_memory, 0);
    step();
    settle();
    chk("h_active_stay", active, 0);
    reset = 1'b1;
    #1;
    chk("h_rst_active", active, 1);
    chk("h_rst_err", bus_error, 0);
    chk("h_rst_rdm", read_data_memory, 0);
    reset = 1'b0;
    idle();
    step();

    drive(1, 0, 0, 32'h9000, 32'h0, 4'hF, 1, 32'h0);
    settle();
    step();
    settle();
    chk("mr_access_rd", data_read, 1);
    reset = 1'b1;
    #1;
    chk("mr_rd_drop", data_read, 0);
    chk("mr_stall_drop", stall_memory, 0);
    reset = 1'b0;
    idle();
    step();
    settle();
    chk("mr_idle_rd", data_read, 0);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
